ctrl_decode_stage: RTL and testbench

//  Second-generation control decoder for the pipelined RISC-V core; it sits between the D and E stages.

---
 rtl/riscv_ctrl_pkg.sv | 56 +++++
 rtl/ctrl_decode_comb.sv | 95 +++++++++
 rtl/ctrl_decode_stage.sv | 132 +++++++++++++
 tb/tb_ctrl_decode_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the ID/EX control decoder: opcodes, operand/result selects,
// the control-word layout and the MUL/DIV sequencer state.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  localparam logic [6:0] F7_MEXT   = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_PC4    = 2'b10;
  localparam logic [1:0] RES_PC_IMM = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  // Wide enough to hold any latency in 1..16.
  localparam int CNT_W = $clog2(16) + 1;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       md;
    logic [2:0] md_op;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational decode of opcode/funct fields into the control word,
// plus the EX occupancy of a MUL/DIV op.
module ctrl_decode_comb
  import riscv_ctrl_pkg::*;
#(
  parameter int EN_MEXT = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  output ctrl_t            ctrl_o,
  output logic             nop_o,
  output logic [CNT_W-1:0] lat_o
);

  // Opcode decode table; unknown opcodes leave only the illegal flag set.
  always_comb begin
    ctrl_o = '0;
    nop_o  = 1'b0;
    lat_o  = funct3_i[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    case (op_i)
      OP_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_src    = IMM_I;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.result_src = RES_MEM;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.imm_src   = IMM_S;
        ctrl_o.alu_src   = 1'b1;
      end
      OP_RTYPE: begin
        if (funct7_i == F7_MEXT) begin
          if (EN_MEXT != 0) begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALUOP_FUNCT;
            ctrl_o.md        = 1'b1;
            ctrl_o.md_op     = funct3_i;
          end else begin
            ctrl_o.illegal = 1'b1;
          end
        end else begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALUOP_FUNCT;
        end
      end
      OP_IALU: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_src   = IMM_I;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ctrl_o.branch  = 1'b1;
        ctrl_o.imm_src = IMM_B;
        ctrl_o.alu_op  = ALUOP_SUB;
      end
      OP_JAL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_src    = IMM_J;
        ctrl_o.jump       = 1'b1;
        ctrl_o.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_src    = IMM_I;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.result_src = RES_PC4;
      end
      OP_LUI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_src   = IMM_U;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALUOP_PASSB;
      end
      OP_AUIPC: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.imm_src    = IMM_U;
        ctrl_o.result_src = RES_PC_IMM;
      end
      OP_NOP: begin
        nop_o = 1'b1;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID/EX control register with MUL/DIV occupancy sequencing and backpressure
// toward the D stage.
module ctrl_decode_stage
  import riscv_ctrl_pkg::*;
#(
  parameter int EN_MEXT = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_d,
  input  logic [6:0] op_d,
  input  logic [2:0] funct3_d,
  input  logic [6:0] funct7_d,
  input  logic       stall_d,
  input  logic       flush_e,
  output logic       busy_o,
  output logic       valid_e,
  output logic       reg_write_e,
  output logic       alu_src_e,
  output logic       mem_write_e,
  output logic       branch_e,
  output logic       jump_e,
  output logic [2:0] imm_src_e,
  output logic [1:0] result_src_e,
  output logic [1:0] alu_op_e,
  output logic       md_e,
  output logic [2:0] md_op_e,
  output logic       md_start_e,
  output logic       md_done_o,
  output logic       illegal_e
);

  ctrl_t            dec_s;
  logic             nop_s;
  logic [CNT_W-1:0] lat_s;

  ctrl_t            e_q,     e_d;
  logic             vld_q,   vld_d;
  logic             start_q, start_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  ctrl_decode_comb #(
    .EN_MEXT (EN_MEXT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_dec (
    .op_i     (op_d),
    .funct3_i (funct3_d),
    .funct7_i (funct7_d),
    .ctrl_o   (dec_s),
    .nop_o    (nop_s),
    .lat_o    (lat_s)
  );

  // Next E-register contents and sequencer state, in priority order.
  always_comb begin
    e_d     = e_q;
    vld_d   = vld_q;
    start_d = start_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_e) begin
      e_d     = '0;
      vld_d   = 1'b0;
      start_d = 1'b0;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_BUSY) begin
      start_d = 1'b0;
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (stall_d || !valid_d) begin
      e_d     = '0;
      vld_d   = 1'b0;
      start_d = 1'b0;
    end else begin
      // A NOP encoding is accepted but enters E as a bubble.
      e_d     = nop_s ? '0 : dec_s;
      vld_d   = ~nop_s;
      start_d = dec_s.md;
      if (dec_s.md && (lat_s > CNT_W'(1))) begin
        state_d = ST_BUSY;
        cnt_d   = lat_s - CNT_W'(1);
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // ID/EX register and sequencer state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q     <= '0;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      vld_q   <= vld_d;
      start_q <= start_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_e      = vld_q;
  assign reg_write_e  = e_q.reg_write;
  assign alu_src_e    = e_q.alu_src;
  assign mem_write_e  = e_q.mem_write;
  assign branch_e     = e_q.branch;
  assign jump_e       = e_q.jump;
  assign imm_src_e    = e_q.imm_src;
  assign result_src_e = e_q.result_src;
  assign alu_op_e     = e_q.alu_op;
  assign md_e         = e_q.md;
  assign md_op_e      = e_q.md_op;
  assign md_start_e   = start_q;
  assign illegal_e    = e_q.illegal;

  assign busy_o    = (EN_MEXT != 0) ? (state_q == ST_BUSY) : 1'b0;
  assign md_done_o = vld_q & e_q.md & (state_q == ST_IDLE);

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: decode table sweep plus MUL/DIV,
// flush, stall and reset sequences; a second instance has the M-extension off.
module tb_ctrl_decode_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_d = 1'b0;
  logic [6:0] op_d = 7'd0;
  logic [2:0] funct3_d = 3'd0;
  logic [6:0] funct7_d = 7'd0;
  logic       stall_d = 1'b0;
  logic       flush_e = 1'b0;

  logic       busy_o, valid_e, reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e;
  logic [2:0] imm_src_e, md_op_e;
  logic [1:0] result_src_e, alu_op_e;
  logic       md_e, md_start_e, md_done_o, illegal_e;

  logic       n_busy, n_valid, n_rw, n_as, n_mw, n_br, n_j;
  logic [2:0] n_imm, n_mdop;
  logic [1:0] n_res, n_aop;
  logic       n_md, n_start, n_done, n_ill;

  ctrl_decode_stage #(.EN_MEXT(1), .MUL_LAT(1), .DIV_LAT(8)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .op_d(op_d), .funct3_d(funct3_d),
    .funct7_d(funct7_d), .stall_d(stall_d), .flush_e(flush_e), .busy_o(busy_o),
    .valid_e(valid_e), .reg_write_e(reg_write_e), .alu_src_e(alu_src_e),
    .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e),
    .imm_src_e(imm_src_e), .result_src_e(result_src_e), .alu_op_e(alu_op_e),
    .md_e(md_e), .md_op_e(md_op_e), .md_start_e(md_start_e),
    .md_done_o(md_done_o), .illegal_e(illegal_e)
  );

  ctrl_decode_stage #(.EN_MEXT(0), .MUL_LAT(2), .DIV_LAT(8)) dut_n (
    .clk(clk), .rst(rst), .valid_d(valid_d), .op_d(op_d), .funct3_d(funct3_d),
    .funct7_d(funct7_d), .stall_d(stall_d), .flush_e(flush_e), .busy_o(n_busy),
    .valid_e(n_valid), .reg_write_e(n_rw), .alu_src_e(n_as),
    .mem_write_e(n_mw), .branch_e(n_br), .jump_e(n_j),
    .imm_src_e(n_imm), .result_src_e(n_res), .alu_op_e(n_aop),
    .md_e(n_md), .md_op_e(n_mdop), .md_start_e(n_start),
    .md_done_o(n_done), .illegal_e(n_ill)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      name;
    logic       vld;
    logic       stl;
    logic       fls;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [13:0] exp; // {valid,rw,alusrc,mw,br,jmp,imm[3],res[2],aluop[2],illegal}
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] e_word();
    return {valid_e, reg_write_e, alu_src_e, mem_write_e, branch_e, jump_e,
            imm_src_e, result_src_e, alu_op_e, illegal_e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic s, input logic f);
    valid_d  = v;
    op_d     = op;
    funct3_d = f3;
    funct7_d = f7;
    stall_d  = s;
    flush_e  = f;
  endtask

  // Watchdog: the directed run is a fixed number of cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"load",   1'b1, 1'b0, 1'b0, 7'b0000011, 3'b010, 7'b0000000, 14'b1_1_1_0_0_0_000_01_00_0};
    vecs[1]  = '{"store",  1'b1, 1'b0, 1'b0, 7'b0100011, 3'b010, 7'b0000000, 14'b1_0_1_1_0_0_001_00_00_0};
    vecs[2]  = '{"rtype",  1'b1, 1'b0, 1'b0, 7'b0110011, 3'b000, 7'b0000000, 14'b1_1_0_0_0_0_000_00_10_0};
    vecs[3]  = '{"rsub",   1'b1, 1'b0, 1'b0, 7'b0110011, 3'b000, 7'b0100000, 14'b1_1_0_0_0_0_000_00_10_0};
    vecs[4]  = '{"ialu",   1'b1, 1'b0, 1'b0, 7'b0010011, 3'b001, 7'b0000000, 14'b1_1_1_0_0_0_000_00_10_0};
    vecs[5]  = '{"branch", 1'b1, 1'b0, 1'b0, 7'b1100011, 3'b000, 7'b0000000, 14'b1_0_0_0_1_0_010_00_01_0};
    vecs[6]  = '{"jal",    1'b1, 1'b0, 1'b0, 7'b1101111, 3'b000, 7'b0000000, 14'b1_1_0_0_0_1_011_10_00_0};
    vecs[7]  = '{"jalr",   1'b1, 1'b0, 1'b0, 7'b1100111, 3'b000, 7'b0000000, 14'b1_1_1_0_0_1_000_10_00_0};
    vecs[8]  = '{"lui",    1'b1, 1'b0, 1'b0, 7'b0110111, 3'b000, 7'b0000000, 14'b1_1_1_0_0_0_100_00_11_0};
    vecs[9]  = '{"auipc",  1'b1, 1'b0, 1'b0, 7'b0010111, 3'b000, 7'b0000000, 14'b1_1_0_0_0_0_100_11_00_0};
    vecs[10] = '{"nop",    1'b1, 1'b0, 1'b0, 7'b0000000, 3'b000, 7'b0000000, 14'b0_0_0_0_0_0_000_00_00_0};
    vecs[11] = '{"illegal",1'b1, 1'b0, 1'b0, 7'b1111111, 3'b000, 7'b0000000, 14'b1_0_0_0_0_0_000_00_00_1};
    vecs[12] = '{"novalid",1'b0, 1'b0, 1'b0, 7'b0000011, 3'b000, 7'b0000000, 14'b0_0_0_0_0_0_000_00_00_0};
    vecs[13] = '{"stall",  1'b1, 1'b1, 1'b0, 7'b0000011, 3'b000, 7'b0000000, 14'b0_0_0_0_0_0_000_00_00_0};
    vecs[14] = '{"stlfls", 1'b1, 1'b1, 1'b1, 7'b0000011, 3'b000, 7'b0000000, 14'b0_0_0_0_0_0_000_00_00_0};

    // Reset state
    step();
    chk("rst_word", 32'(e_word()), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_md", 32'({md_e, md_start_e, md_done_o}), 32'h0);
    rst = 1'b1;

    // Decode sweep: vector applied in cycle N, E fields checked in N+1
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].vld, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].stl, vecs[i].fls);
      step();
      chk(vecs[i].name, 32'(e_word()), 32'(vecs[i].exp));
      chk({vecs[i].name, "_md"}, 32'({md_e, busy_o}), 32'h0);
    end

    // DIV with DIV_LAT=8; the following ADD is held on the D inputs
    drive(1'b1, 7'b0110011, 3'b100, 7'b0000001, 1'b0, 1'b0);
    step();
    chk("div_c1_start", 32'(md_start_e), 32'h1);
    chk("div_c1_busy", 32'(busy_o), 32'h1);
    chk("div_c1_md", 32'({md_e, md_op_e, md_done_o}), 32'({1'b1, 3'b100, 1'b0}));
    chk("nomext_div_ill", 32'({n_ill, n_valid, n_rw, n_md, n_busy}), 32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
    for (int c = 2; c <= 7; c++) begin
      step();
      chk($sformatf("div_c%0d", c), 32'({busy_o, md_done_o, md_start_e, valid_e, md_e}),
          32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1}));
    end
    step();
    chk("div_c8_done", 32'({busy_o, md_done_o, valid_e, md_e}), 32'({1'b0, 1'b1, 1'b1, 1'b1}));
    step();
    chk("div_c9_add", 32'({valid_e, md_e, reg_write_e, alu_op_e, md_done_o}),
        32'({1'b1, 1'b0, 1'b1, 2'b10, 1'b0}));

    // Back-to-back MUL with MUL_LAT=1
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000001, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mul1_%0d", k), 32'({busy_o, md_start_e, md_done_o, md_e}),
          32'({1'b0, 1'b1, 1'b1, 1'b1}));
      chk($sformatf("nomext_mul_%0d", k), 32'({n_ill, n_md}), 32'({1'b1, 1'b0}));
    end

    // Flush during DIV cycle 4
    drive(1'b1, 7'b0110011, 3'b101, 7'b0000001, 1'b0, 1'b0);
    step();
    chk("fdiv_c1", 32'({busy_o, md_start_e, md_op_e}), 32'({1'b1, 1'b1, 3'b101}));
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
    step();
    step();
    step();
    chk("fdiv_c4", 32'({busy_o, md_done_o}), 32'({1'b1, 1'b0}));
    flush_e = 1'b1;
    step();
    chk("fdiv_c5", 32'({valid_e, busy_o, md_done_o, md_e}), 32'h0);
    flush_e = 1'b0;
    step();
    chk("fdiv_c6_add", 32'({valid_e, md_e, reg_write_e, alu_op_e}), 32'({1'b1, 1'b0, 1'b1, 2'b10}));

    // Asynchronous reset in the middle of a DIV
    drive(1'b1, 7'b0110011, 3'b110, 7'b0000001, 1'b0, 1'b0);
    step();
    step();
    chk("rdiv_busy", 32'(busy_o), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("rdiv_async", 32'({e_word(), busy_o, md_e, md_start_e, md_done_o}), 32'h0);
    drive(1'b1, 7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);
    step();
    chk("rdiv_held", 32'({e_word(), busy_o}), 32'h0);
    rst = 1'b1;
    step();
    chk("rdiv_first", 32'(e_word()), 32'(14'b1_1_1_0_0_0_000_01_00_0));
    chk("rdiv_first_busy", 32'({busy_o, md_e}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
